// File: rtl/fixed_subtractor_pipe_pkg.sv
// Shared number-format defaults and operation codes for the sign-magnitude
// fixed-point datapath (subtractor pipe and adder pipe).
package fixed_subtractor_pipe_pkg;

  // Word length: bit WL-1 is the sign (1 = negative), bits WL-2:0 the magnitude.
  localparam int WL_DEFAULT  = 32;
  // Integer bits including the sign; the magnitude has IWL-1 integer bits.
  localparam int IWL_DEFAULT = 8;

  // Operation selector: a subtract is an add with the subtrahend sign flipped.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

endpackage

// File: rtl/fixed_subtractor_pipe_sm_addsub_core.sv
// Combinational sign-magnitude adder core with saturation and -0 cleanup.
// The caller supplies the effective sign of the second operand, so the same
// core serves both an adder and a subtractor pipe.
module sm_addsub_core
  import fixed_subtractor_pipe_pkg::*;
#(
  parameter int WL = WL_DEFAULT
) (
  input  logic          a_sign,
  input  logic          b_sign,
  input  logic [WL-2:0] a_mag,
  input  logic [WL-2:0] b_mag,
  input  logic          a_ge_b,
  output logic [WL-1:0] c,
  output logic          ovf
);

  logic [WL-1:0] sum;
  logic [WL-2:0] diff;
  logic [WL-2:0] mag;
  logic          sign;

  // Add magnitudes on equal signs, otherwise subtract the smaller from the
  // larger; saturate an oversized sum and force a zero result to +0.
  always_comb begin
    sum  = {1'b0, a_mag} + {1'b0, b_mag};
    diff = a_ge_b ? (a_mag - b_mag) : (b_mag - a_mag);
    mag  = '0;
    sign = 1'b0;
    c    = '0;
    ovf  = 1'b0;
    if (a_sign == b_sign) begin
      if (sum[WL-1]) begin
        ovf = 1'b1;
        c   = {a_sign, {(WL-1){1'b1}}};
      end else begin
        mag  = sum[WL-2:0];
        sign = a_sign;
      end
    end else begin
      mag  = diff;
      sign = a_ge_b ? a_sign : b_sign;
    end
    if (!ovf) begin
      c = (mag == '0) ? '0 : {sign, mag};
    end
  end

endmodule

// File: rtl/fixed_subtractor_pipe.sv
// Two-stage pipelined sign-magnitude subtractor c = a - b with valid/ready
// handshakes on both sides. Stage 1 latches operands and the magnitude
// compare; stage 2 latches the saturated result. Up to two beats buffer.
module fixed_subtractor_pipe
  import fixed_subtractor_pipe_pkg::*;
#(
  parameter int WL  = WL_DEFAULT,
  parameter int IWL = IWL_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] a,
  input  logic [WL-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] c,
  output logic          ovf
);

  localparam addsub_op_e OP = OP_SUB;

  logic          s1_valid;
  logic          s1_a_sign;
  logic          s1_sb_eff;
  logic [WL-2:0] s1_a_mag;
  logic [WL-2:0] s1_b_mag;
  logic          s1_a_ge_b;

  logic          s2_valid;
  logic [WL-1:0] c_q;
  logic          ovf_q;

  logic          s1_adv;
  logic          s2_adv;
  logic [WL-1:0] core_c;
  logic          core_ovf;

  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign c         = c_q;
  assign ovf       = ovf_q;

  // Stage 1: capture operands, the effective subtrahend sign and the
  // magnitude compare whenever the stage is free to move.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a_sign <= 1'b0;
      s1_sb_eff <= 1'b0;
      s1_a_mag  <= '0;
      s1_b_mag  <= '0;
      s1_a_ge_b <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a_sign <= a[WL-1];
        s1_sb_eff <= b[WL-1] ^ (OP == OP_SUB);
        s1_a_mag  <= a[WL-2:0];
        s1_b_mag  <= b[WL-2:0];
        s1_a_ge_b <= (a[WL-2:0] >= b[WL-2:0]);
      end
    end
  end

  sm_addsub_core #(
    .WL(WL)
  ) u_core (
    .a_sign(s1_a_sign),
    .b_sign(s1_sb_eff),
    .a_mag (s1_a_mag),
    .b_mag (s1_b_mag),
    .a_ge_b(s1_a_ge_b),
    .c     (core_c),
    .ovf   (core_ovf)
  );

  // Stage 2: register the result; it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      c_q      <= '0;
      ovf_q    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        c_q   <= core_c;
        ovf_q <= core_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fixed_subtractor_pipe.sv
// Self-checking bench for fixed_subtractor_pipe: directed vector table,
// backpressure and reset sequences, and a randomized scoreboard run against
// an arithmetic reference model.
module tb_fixed_subtractor_pipe;

  localparam int WL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WL-1:0] a = '0;
  logic [WL-1:0] b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WL-1:0] c;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [32:0] prev_res = '0;
  logic        in_fired;
  int          out_count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  fixed_subtractor_pipe #(
    .WL (32),
    .IWL(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Reference: signed difference with plain integers, then saturate/normalise.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    longint vx, vy, d, m;
    longint maxm;
    logic   s;
    maxm = (longint'(1) << 31) - 1;
    vx = x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
    vy = y[31] ? -longint'(y[30:0]) : longint'(y[30:0]);
    d  = vx - vy;
    s  = (d < 0);
    m  = s ? -d : d;
    if (m > maxm) return {1'b1, s, 31'h7FFFFFFF};
    if (m == 0) return 33'd0;
    return {1'b0, s, m[30:0]};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 5))
      0: w = 32'h0000_0000;
      1: w = 32'h8000_0000;
      2: w = {w[31], 31'h7FFF_FFFF};
      3: w = {w[31], 15'd0, w[15:0]};
      default: ;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, and keep
  // the scoreboard and hold checks up to date for the coming rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] ia,
                               input logic [31:0] ib, input logic ordy);
    @(negedge clk);
    rst = r; in_valid = v; a = ia; b = ib; out_ready = ordy;
    #1;
    in_fired = 1'b0;
    if (r) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_result", 64'({ovf, c}), 64'(prev_res));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ia, ib));
        in_fired = 1'b1;
      end
      if (out_valid && out_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got c=%h ovf=%b with no beat outstanding", c, ovf);
        end else begin
          checkOutput("sb_result", 64'({ovf, c}), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_res   = {ovf, c};
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      n++;
    end
    checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  initial begin
    logic [31:0] beats_a[4];
    logic [31:0] beats_b[4];
    int idx;

    vecs[0] = '{32'h0300_0000, 32'h0100_0000, 32'h0200_0000, 1'b0};
    vecs[1] = '{32'h0100_0000, 32'h0300_0000, 32'h8200_0000, 1'b0};
    vecs[2] = '{32'h8200_0000, 32'h0180_0000, 32'h8380_0000, 1'b0};
    vecs[3] = '{32'h7F80_0000, 32'h8100_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[4] = '{32'hFF80_0000, 32'h0100_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
    out_count = 0;

    // Reset state
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_c", 64'(c), 64'd0);
    checkOutput("reset_ovf", 64'(ovf), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors with latency check
    foreach (vecs[i]) begin
      applyStimulus(1'b0, 1'b1, vecs[i].a, vecs[i].b, 1'b1);
      checkOutput("vec_accept", 64'(in_fired), 64'd1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("vec_lat1_valid", 64'(out_valid), 64'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
      checkOutput("vec_lat2_valid", 64'(out_valid), 64'd1);
      checkOutput("vec_c", 64'(c), 64'(vecs[i].c));
      checkOutput("vec_ovf", 64'(ovf), 64'(vecs[i].ovf));
    end
    drain(5);

    // Backpressure: 4 beats offered, consumer stalled for 5 cycles
    for (int i = 0; i < 4; i++) begin
      beats_a[i] = rand_word();
      beats_b[i] = rand_word();
    end
    idx = 0;
    out_count = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      applyStimulus(1'b0, 1'b1, beats_a[idx], beats_b[idx], 1'b0);
      checkOutput("bp_in_ready", 64'(in_ready), (cyc < 2) ? 64'd1 : 64'd0);
      if (in_fired) idx++;
    end
    checkOutput("bp_accepted", 64'(idx), 64'd2);
    checkOutput("bp_first_result", 64'({ovf, c}), 64'(model(beats_a[0], beats_b[0])));
    for (int cyc = 0; cyc < 12 && idx < 4; cyc++) begin
      applyStimulus(1'b0, 1'b1, beats_a[idx], beats_b[idx], 1'b1);
      if (in_fired) idx++;
    end
    checkOutput("bp_all_accepted", 64'(idx), 64'd4);
    drain(6);
    checkOutput("bp_out_count", 64'(out_count), 64'd4);

    // Full throughput: one result per cycle
    for (int cyc = 0; cyc < 16; cyc++) begin
      applyStimulus(1'b0, 1'b1, rand_word(), rand_word(), 1'b1);
      checkOutput("tp_in_ready", 64'(in_ready), 64'd1);
      if (cyc >= 2) checkOutput("tp_out_valid", 64'(out_valid), 64'd1);
    end
    drain(5);

    // Reset with two beats in flight
    applyStimulus(1'b0, 1'b1, 32'h0500_0000, 32'h0100_0000, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0600_0000, 32'h0100_0000, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("rst_mid_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_c", 64'(c), 64'd0);
    checkOutput("rst_mid_ovf", 64'(ovf), 64'd0);
    checkOutput("rst_mid_in_ready", 64'(in_ready), 64'd1);
    out_count = 0;
    for (int cyc = 0; cyc < 5; cyc++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1);
    checkOutput("rst_mid_no_stale", 64'(out_count), 64'd0);

    // Randomized traffic against the reference model
    for (int cyc = 0; cyc < 400; cyc++) begin
      applyStimulus(1'b0, ($urandom_range(0, 3) != 0), rand_word(), rand_word(),
                    ($urandom_range(0, 2) != 0));
    end
    drain(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
